// File: rtl/dm_pkg.sv
// Shared encodings for the data-memory responder.
// Holds the FSM state encoding, the store-size encoding and the load-type encoding.
// Both dm_responder and dm_load_ext use these encodings.
package dm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        WS_WORD = 2'b00,
        WS_HALF = 2'b01,
        WS_BYTE = 2'b10,
        WS_RSVD = 2'b11
    } store_size_t;

    typedef enum logic [2:0] {
        LD_LW  = 3'b000,
        LD_LHU = 3'b001,
        LD_LH  = 3'b010,
        LD_LBU = 3'b011,
        LD_LB  = 3'b100
    } load_type_t;

endpackage

// File: rtl/dm_load_ext.sv
// Load extraction and extension (combinational).
// Ports:
//   word      in  32  full storage word
//   byte_sel  in   2  byte address bits [1:0]
//   load_type in   3  lw / lhu / lh / lbu / lb; any other value gives 0
//   result    out 32  selected field, zero- or sign-extended
module dm_load_ext
    import dm_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  byte_sel,
    input  logic [2:0]  load_type,
    output logic [31:0] result
);

    logic [15:0] half;
    logic [7:0]  bytev;

    always_comb begin
        half   = byte_sel[1] ? word[31:16] : word[15:0];
        bytev  = word[{byte_sel, 3'b000} +: 8];
        result = '0;
        case (load_type)
            LD_LW:   result = word;
            LD_LHU:  result = {16'h0000, half};
            LD_LH:   result = {{16{half[15]}}, half};
            LD_LBU:  result = {24'h000000, bytev};
            LD_LB:   result = {{24{bytev[7]}}, bytev};
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/dm_responder.sv
// Data-memory responder for MEM-stage loads and stores with a fixed wait-state latency.
// The responder owns a word-organised storage array. It applies byte and halfword write masking, and it
// extracts and extends load data. Completion is signalled by a one-cycle Ack.
// Ports:
//   Clk          in   1   clock, rising edge
//   Rst          in   1   asynchronous active-low reset
//   Req          in   1   request valid, held until Ack
//   Addr         in  32   byte address
//   MemWrite     in   1   1 = store, 0 = load
//   MemWriteCtr  in   2   store size
//   WriteData    in  32   right-aligned store data
//   MemOutCtr    in   3   load type
//   Ack          out  1   one-cycle completion pulse
//   ReadData     out 32   load result in the Ack cycle, otherwise 0
//   AddrErr      out  1   set together with Ack for a misaligned, out-of-range or reserved-encoding request
module dm_responder
    import dm_pkg::*;
#(
    parameter int ADDR_BITS   = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        Req,
    input  logic [31:0] Addr,
    input  logic        MemWrite,
    input  logic [1:0]  MemWriteCtr,
    input  logic [31:0] WriteData,
    input  logic [2:0]  MemOutCtr,
    output logic        Ack,
    output logic [31:0] ReadData,
    output logic        AddrErr
);

    localparam int DEPTH = 1 << ADDR_BITS;
    localparam int CNT_W = (WAIT_CYCLES < 2) ? 1 : $clog2(WAIT_CYCLES + 1);

    state_t state, state_nxt;
    logic [CNT_W-1:0] cnt;

    logic [31:0] cap_addr, cap_wdata;
    logic        cap_write;
    logic [1:0]  cap_wsize;
    logic [2:0]  cap_ltype;

    logic [31:0] rd_q;
    logic        err_q;

    logic [31:0] mem [DEPTH];

    logic        accept, commit;
    logic [31:0] acc_addr, acc_wdata;
    logic        acc_write;
    logic [1:0]  acc_wsize;
    logic [2:0]  acc_ltype;
    logic [ADDR_BITS-1:0] idx;
    logic        range_err, align_err, enc_err, err;
    logic [3:0]  be;
    logic [31:0] lane, old_word, new_word, load_val;

    assign accept = (state == ST_IDLE) && Req;

    // With zero wait states, the access commits on the same edge that accepts it.
    always_comb begin
        if (WAIT_CYCLES == 0) commit = accept;
        else                  commit = (state == ST_BUSY) && (cnt == CNT_W'(1));
    end

    // The captured fields are valid only after acceptance. In IDLE, the live inputs take their place. The
    // live inputs matter only when the access commits on the accepting edge.
    always_comb begin
        if (state == ST_IDLE) begin
            acc_addr  = Addr;
            acc_wdata = WriteData;
            acc_write = MemWrite;
            acc_wsize = MemWriteCtr;
            acc_ltype = MemOutCtr;
        end else begin
            acc_addr  = cap_addr;
            acc_wdata = cap_wdata;
            acc_write = cap_write;
            acc_wsize = cap_wsize;
            acc_ltype = cap_ltype;
        end
    end

    assign idx = acc_addr[ADDR_BITS+1:2];

    always_comb begin
        range_err = (acc_addr >> (ADDR_BITS + 2)) != 32'd0;
        align_err = 1'b0;
        enc_err   = 1'b0;
        if (acc_write) begin
            case (acc_wsize)
                WS_WORD: align_err = acc_addr[1:0] != 2'b00;
                WS_HALF: align_err = acc_addr[0];
                WS_BYTE: align_err = 1'b0;
                default: enc_err   = 1'b1;
            endcase
        end else begin
            case (acc_ltype)
                LD_LW:         align_err = acc_addr[1:0] != 2'b00;
                LD_LHU, LD_LH: align_err = acc_addr[0];
                LD_LBU, LD_LB: align_err = 1'b0;
                default:       enc_err   = 1'b1;
            endcase
        end
        err = range_err | align_err | enc_err;
    end

    // Replicate the store data across all byte lanes so that the byte enables alone select the target.
    always_comb begin
        case (acc_wsize)
            WS_WORD: begin be = 4'b1111;                              lane = acc_wdata;              end
            WS_HALF: begin be = acc_addr[1] ? 4'b1100 : 4'b0011;      lane = {2{acc_wdata[15:0]}};   end
            WS_BYTE: begin be = 4'b0001 << acc_addr[1:0];             lane = {4{acc_wdata[7:0]}};    end
            default: begin be = 4'b0000;                              lane = '0;                     end
        endcase
    end

    assign old_word = mem[idx];

    always_comb begin
        for (int k = 0; k < 4; k++) begin
            new_word[8*k +: 8] = be[k] ? lane[8*k +: 8] : old_word[8*k +: 8];
        end
    end

    dm_load_ext u_load_ext (
        .word      (old_word),
        .byte_sel  (acc_addr[1:0]),
        .load_type (acc_ltype),
        .result    (load_val)
    );

    // Storage has no reset. Writes are blocked while Rst is low, so a request seen in reset cannot commit.
    always_ff @(posedge Clk) begin
        if (Rst && commit && acc_write && !err) begin
            mem[idx] <= new_word;
        end
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) state <= ST_IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (Req) state_nxt = (WAIT_CYCLES == 0) ? ST_DONE : ST_BUSY;
            ST_BUSY: if (cnt == CNT_W'(1)) state_nxt = ST_DONE;
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            cnt       <= '0;
            cap_addr  <= '0;
            cap_wdata <= '0;
            cap_write <= 1'b0;
            cap_wsize <= '0;
            cap_ltype <= '0;
            rd_q      <= '0;
            err_q     <= 1'b0;
        end else begin
            if (accept) begin
                cnt       <= CNT_W'(WAIT_CYCLES);
                cap_addr  <= Addr;
                cap_wdata <= WriteData;
                cap_write <= MemWrite;
                cap_wsize <= MemWriteCtr;
                cap_ltype <= MemOutCtr;
            end else if (state == ST_BUSY) begin
                cnt <= cnt - 1'b1;
            end
            if (commit) begin
                rd_q  <= (err || acc_write) ? 32'd0 : load_val;
                err_q <= err;
            end
        end
    end

    always_comb begin
        Ack      = (state == ST_DONE);
        ReadData = Ack ? rd_q : 32'd0;
        AddrErr  = Ack & err_q;
    end

endmodule

// File: tb/tb_dm_responder.sv
module tb_dm_responder;

    localparam int ADDR_BITS = 10;
    localparam int MEM_BYTES = 4 << ADDR_BITS;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req  [2];
    logic [31:0] addr [2];
    logic        we   [2];
    logic [1:0]  wc   [2];
    logic [31:0] wd   [2];
    logic [2:0]  oc   [2];
    logic        ack  [2];
    logic [31:0] rd   [2];
    logic        err  [2];

    // Byte-addressed reference storage, one image per DUT.
    logic [7:0]  bmem [2][MEM_BYTES];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    dm_responder #(.ADDR_BITS(ADDR_BITS), .WAIT_CYCLES(2)) dut_w2 (
        .Clk(clk), .Rst(rst_n), .Req(req[0]), .Addr(addr[0]), .MemWrite(we[0]),
        .MemWriteCtr(wc[0]), .WriteData(wd[0]), .MemOutCtr(oc[0]),
        .Ack(ack[0]), .ReadData(rd[0]), .AddrErr(err[0])
    );

    dm_responder #(.ADDR_BITS(ADDR_BITS), .WAIT_CYCLES(0)) dut_w0 (
        .Clk(clk), .Rst(rst_n), .Req(req[1]), .Addr(addr[1]), .MemWrite(we[1]),
        .MemWriteCtr(wc[1]), .WriteData(wd[1]), .MemOutCtr(oc[1]),
        .Ack(ack[1]), .ReadData(rd[1]), .AddrErr(err[1])
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    // The reference works on bytes. The access size determines the bytes touched, and the address must be a
    // multiple of the size and inside the byte range.
    task automatic ref_access(input int s, input logic w, input logic [1:0] c, input logic [31:0] d,
                              input logic [2:0] o, input logic [31:0] a,
                              output logic e, output logic [31:0] r);
        int  sz;
        bit  sgn;
        e = 1'b0; r = 32'd0; sz = 0; sgn = 1'b0;
        if (w) begin
            case (c)
                2'd0: sz = 4;
                2'd1: sz = 2;
                2'd2: sz = 1;
                default: e = 1'b1;
            endcase
        end else begin
            case (o)
                3'd0: sz = 4;
                3'd1: sz = 2;
                3'd2: begin sz = 2; sgn = 1'b1; end
                3'd3: sz = 1;
                3'd4: begin sz = 1; sgn = 1'b1; end
                default: e = 1'b1;
            endcase
        end
        if (!e && (a >= MEM_BYTES || (a % sz) != 0)) e = 1'b1;
        if (!e) begin
            if (w) begin
                for (int k = 0; k < sz; k++) bmem[s][a + k] = d[8*k +: 8];
            end else begin
                for (int k = 0; k < sz; k++) r[8*k +: 8] = bmem[s][a + k];
                if (sgn) for (int b = 8*sz; b < 32; b++) r[b] = r[8*sz - 1];
            end
        end
    endtask

    task automatic do_access(input int s, input logic w, input logic [1:0] c, input logic [31:0] d,
                             input logic [2:0] o, input logic [31:0] a, output logic [31:0] obs);
        logic        exp_err;
        logic [31:0] exp_rd;
        int          n;
        int          lat;
        lat = (s == 0) ? 3 : 1;
        ref_access(s, w, c, d, o, a, exp_err, exp_rd);
        we[s] = w; wc[s] = c; wd[s] = d; oc[s] = o; addr[s] = a; req[s] = 1'b1;
        n = 0;
        do begin
            @(posedge clk); @(negedge clk);
            n++;
        end while (!ack[s] && n < 12);
        check("latency", 32'(n), 32'(lat));
        check("read_data", rd[s], exp_rd);
        check("addr_err", 32'(err[s]), 32'(exp_err));
        obs = rd[s];
        req[s] = 1'b0;
        @(posedge clk); @(negedge clk);
        check("ack_one_cycle", 32'(ack[s]), 32'd0);
        check("read_data_idle", rd[s], 32'd0);
    endtask

    // Three word loads with Req held high throughout. Addr is moved to another valid word right after each
    // acceptance.
    task automatic b2b(input int s, input logic [31:0] a0, input logic [31:0] a1, input logic [31:0] a2);
        logic [31:0] al [3];
        logic        exp_err;
        logic [31:0] exp_rd;
        int          n;
        int          lat;
        al[0] = a0; al[1] = a1; al[2] = a2;
        lat = (s == 0) ? 3 : 1;
        we[s] = 1'b0; oc[s] = 3'd0; req[s] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            ref_access(s, 1'b0, 2'd0, 32'd0, 3'd0, al[i], exp_err, exp_rd);
            addr[s] = al[i];
            if (i > 0) @(posedge clk);
            @(posedge clk); @(negedge clk);
            n = 1;
            addr[s] = al[i] ^ 32'h0000_0040;
            while (!ack[s] && n < 12) begin
                @(posedge clk); @(negedge clk);
                n++;
            end
            check("b2b_latency", 32'(n), 32'(lat));
            check("b2b_read_data", rd[s], exp_rd);
            check("b2b_addr_err", 32'(err[s]), 32'(exp_err));
        end
        req[s] = 1'b0;
        @(posedge clk); @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] obs;
        logic [31:0] a;
        int          s;
        int          r;

        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            req[i] = 1'b0; addr[i] = '0; we[i] = 1'b0; wc[i] = '0; wd[i] = '0; oc[i] = '0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check("reset_ack", 32'(ack[i]), 32'd0);
            check("reset_read_data", rd[i], 32'd0);
            check("reset_addr_err", 32'(err[i]), 32'd0);
        end
        rst_n = 1'b1;
        @(posedge clk); @(negedge clk);

        // Give words 0..31 known contents in both DUTs.
        for (int i = 0; i < 2; i++) begin
            for (int j = 0; j < 32; j++) do_access(i, 1'b1, 2'd0, $urandom, 3'd0, 32'(j * 4), obs);
        end

        // A reset while the store is in BUSY drops the store and produces no Ack.
        we[0] = 1'b1; wc[0] = 2'd0; wd[0] = 32'hDEAD_BEEF; addr[0] = 32'h10; req[0] = 1'b1;
        @(posedge clk); @(negedge clk);
        rst_n = 1'b0; req[0] = 1'b0;
        #1;
        check("midreset_ack", 32'(ack[0]), 32'd0);
        check("midreset_read_data", rd[0], 32'd0);
        check("midreset_addr_err", 32'(err[0]), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); @(negedge clk);
            check("midreset_no_ack", 32'(ack[0]), 32'd0);
        end
        rst_n = 1'b1;
        @(posedge clk); @(negedge clk);
        check("postreset_no_ack", 32'(ack[0]), 32'd0);
        do_access(0, 1'b0, 2'd0, 32'd0, 3'd0, 32'h10, obs);

        // Word store, then read it back.
        do_access(0, 1'b1, 2'd0, 32'h1122_3344, 3'd0, 32'h4, obs);
        do_access(0, 1'b0, 2'd0, 32'd0, 3'd0, 32'h4, obs);
        check("sw_lw", obs, 32'h1122_3344);

        // Byte store. The upper bits of the store data must be ignored.
        do_access(0, 1'b1, 2'd2, 32'h5555_55AA, 3'd0, 32'h5, obs);
        do_access(0, 1'b0, 2'd0, 32'd0, 3'd0, 32'h4, obs);
        check("sb_lw", obs, 32'h1122_AA44);
        do_access(0, 1'b0, 2'd0, 32'd0, 3'd4, 32'h5, obs);
        check("sb_lb", obs, 32'hFFFF_FFAA);
        do_access(0, 1'b0, 2'd0, 32'd0, 3'd3, 32'h5, obs);
        check("sb_lbu", obs, 32'h0000_00AA);

        // Halfword store into the upper half.
        do_access(0, 1'b1, 2'd1, 32'h7777_8001, 3'd0, 32'h6, obs);
        do_access(0, 1'b0, 2'd0, 32'd0, 3'd2, 32'h6, obs);
        check("sh_lh", obs, 32'hFFFF_8001);
        do_access(0, 1'b0, 2'd0, 32'd0, 3'd1, 32'h6, obs);
        check("sh_lhu", obs, 32'h0000_8001);
        do_access(0, 1'b0, 2'd0, 32'd0, 3'd0, 32'h4, obs);
        check("sh_lw", obs, 32'h8001_AA44);

        // Error requests. The word 0 and word 2 readbacks show that none of them wrote storage.
        do_access(0, 1'b0, 2'd0, 32'd0, 3'd0, 32'h2, obs);
        check("err_lw_misaligned", obs, 32'd0);
        do_access(0, 1'b1, 2'd1, 32'hFFFF_FFFF, 3'd0, 32'h3, obs);
        do_access(0, 1'b1, 2'd0, 32'hCAFE_F00D, 3'd0, 32'h1000, obs);
        do_access(0, 1'b1, 2'd3, 32'h1234_5678, 3'd0, 32'h8, obs);
        do_access(0, 1'b0, 2'd0, 32'd0, 3'd6, 32'h8, obs);
        check("err_load_reserved", obs, 32'd0);
        do_access(0, 1'b0, 2'd0, 32'd0, 3'd0, 32'h0, obs);
        do_access(0, 1'b0, 2'd0, 32'd0, 3'd0, 32'h8, obs);

        // Back-to-back loads with Req held high, on both latencies.
        b2b(0, 32'h4, 32'h10, 32'h20);
        b2b(1, 32'h8, 32'h3C, 32'h0);
        do_access(1, 1'b1, 2'd2, 32'h0000_00C3, 3'd0, 32'h9, obs);
        do_access(1, 1'b0, 2'd0, 32'd0, 3'd4, 32'h9, obs);
        check("w0_lb", obs, 32'hFFFF_FFC3);

        // Randomized mix of loads and stores, including out-of-range, misaligned and reserved requests.
        for (int t = 0; t < 90; t++) begin
            s = (t % 3 == 2) ? 1 : 0;
            r = int'($urandom_range(0, 9));
            if (r == 0)      a = 32'h0000_1000 + $urandom_range(0, 255);
            else if (r == 1) a = $urandom;
            else             a = 32'($urandom_range(0, 127));
            do_access(s, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), $urandom,
                      3'($urandom_range(0, 7)), a, obs);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
